// File: rtl/hpdcache_fifo_rr_sched.sv
// Round-robin scheduler draining N_REQ per-requester register FIFOs onto one valid/ready port.
// A grant is held across up to BURST pops, and the output stays stable while the consumer stalls.

module hpdcache_fifo_rr_sched_chk #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic [N_REQ-1:0] push,
  input logic [N_REQ-1:0] pop,
  input logic [N_REQ-1:0] full,
  input logic [N_REQ-1:0] empty,
  input logic             lock,
  input logic [ID_W-1:0]  gnt
);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    ((push & full & ~pop) == '0));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    ((pop & empty) == '0));
  a_gnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
    lock |-> (int'(gnt) < int'(N_REQ)));
endmodule

module hpdcache_fifo_rr_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BURST       = 1,
  parameter type         fifo_data_t = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_w_i,
  output logic [N_REQ-1:0]         req_wok_o,
  input  fifo_data_t [N_REQ-1:0]   req_wdata_i,
  input  logic                     r_i,
  output logic                     rok_o,
  output fifo_data_t               rdata_o,
  output logic [$clog2(N_REQ)-1:0] rid_o
);
  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BCNT_W = $clog2(BURST + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                 state_r, state_n;
  logic [ID_W-1:0]        gnt_r, gnt_n, ptr_r, ptr_n, scan_sel_s, sel_s;
  logic [ID_W:0]          sum_s;
  logic [BCNT_W-1:0]      bcnt_r, bcnt_n, bcnt_inc_s;
  logic [N_REQ-1:0]       full_s, empty_s, one_s, push_s, pop_s;
  fifo_data_t [N_REQ-1:0] head_s;
  logic                   rok_s, pop_any_s, last_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] p);
    if (p == ID_W'(N_REQ - 1)) return '0;
    else return p + ID_W'(1);
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_queue
    fifo_data_t       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_r, rptr_r;
    logic [CNT_W-1:0] cnt_r;

    assign full_s[i]  = (cnt_r == CNT_W'(FIFO_DEPTH));
    assign empty_s[i] = (cnt_r == CNT_W'(0));
    assign one_s[i]   = (cnt_r == CNT_W'(1));
    assign head_s[i]  = mem_r[rptr_r];

    // Payload storage; not reset, occupancy alone decides which entries are live
    always_ff @(posedge clk_i) begin
      if (push_s[i]) mem_r[wptr_r] <= req_wdata_i[i];
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wptr_r <= '0;
        rptr_r <= '0;
        cnt_r  <= '0;
      end else begin
        if (push_s[i]) wptr_r <= ptr_inc(wptr_r);
        if (pop_s[i])  rptr_r <= ptr_inc(rptr_r);
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  // Round-robin scan: first non-empty queue at or after ptr_r (lowest offset wins)
  always_comb begin
    scan_sel_s = ptr_r;
    sum_s      = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      sum_s = {1'b0, ptr_r} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(N_REQ)) sum_s = sum_s - (ID_W+1)'(N_REQ);
      else sum_s = sum_s;
      if (!empty_s[sum_s[ID_W-1:0]]) scan_sel_s = sum_s[ID_W-1:0];
      else scan_sel_s = scan_sel_s;
    end
  end

  // Selection, handshake and per-queue push/pop strobes; a full queue accepts a push when popped
  always_comb begin
    sel_s     = (state_r == LOCKED) ? gnt_r : scan_sel_s;
    rok_s     = ~rst_i & ~empty_s[sel_s];
    pop_any_s = rok_s & r_i;
    pop_s     = '0;
    push_s    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      pop_s[i]  = pop_any_s & (sel_s == ID_W'(i));
      push_s[i] = ~rst_i & req_w_i[i] & (~full_s[i] | pop_s[i]);
    end
  end

  // Output drive; everything forced quiet while reset is asserted
  always_comb begin
    req_wok_o = rst_i ? '0 : ~full_s;
    rok_o     = rok_s;
    rid_o     = rst_i ? '0 : (rok_s ? sel_s : ptr_r);
    rdata_o   = head_s[sel_s];
  end

  // Grant state: lock on a stalled head, continue bursts, rotate past sel when done
  always_comb begin
    state_n    = state_r;
    gnt_n      = gnt_r;
    ptr_n      = ptr_r;
    bcnt_n     = bcnt_r;
    bcnt_inc_s = bcnt_r + BCNT_W'(1);
    last_s     = one_s[sel_s] & ~push_s[sel_s];
    case (state_r)
      IDLE: begin
        if (rok_s && !r_i) begin
          state_n = LOCKED;
          gnt_n   = sel_s;
        end else begin
          state_n = IDLE;
        end
      end
      LOCKED:  state_n = LOCKED;
      default: state_n = IDLE;
    endcase
    if (pop_any_s) begin
      if ((bcnt_inc_s == BCNT_W'(BURST)) || last_s) begin
        state_n = IDLE;
        ptr_n   = id_inc(sel_s);
        bcnt_n  = '0;
      end else begin
        state_n = LOCKED;
        gnt_n   = sel_s;
        bcnt_n  = bcnt_inc_s;
      end
    end else begin
      bcnt_n = bcnt_r;
    end
  end

  // Grant state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      ptr_r   <= '0;
      bcnt_r  <= '0;
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      ptr_r   <= ptr_n;
      bcnt_r  <= bcnt_n;
    end
  end

  hpdcache_fifo_rr_sched_chk #(.N_REQ(N_REQ), .ID_W(ID_W)) u_chk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_s),
    .pop   (pop_s),
    .full  (full_s),
    .empty (empty_s),
    .lock  (state_r == LOCKED),
    .gnt   (gnt_r)
  );
endmodule

// File: tb/tb_hpdcache_fifo_rr_sched.sv
// Directed bench: one instance with BURST=1 (a_*) and one with BURST=2 (b_*), 4 requesters, depth 4.
module tb_hpdcache_fifo_rr_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst, a_r, a_rok, b_rst, b_r, b_rok;
  logic [3:0]      a_w, a_wok, b_w, b_wok;
  logic [3:0][7:0] a_wd, b_wd;
  logic [7:0]      a_rdata, b_rdata;
  logic [1:0]      a_rid, b_rid;
  int checks = 0;
  int errors = 0;

  hpdcache_fifo_rr_sched #(.N_REQ(4), .FIFO_DEPTH(4), .BURST(1), .fifo_data_t(logic [7:0])) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .req_w_i(a_w), .req_wok_o(a_wok), .req_wdata_i(a_wd),
    .r_i(a_r), .rok_o(a_rok), .rdata_o(a_rdata), .rid_o(a_rid));

  hpdcache_fifo_rr_sched #(.N_REQ(4), .FIFO_DEPTH(4), .BURST(2), .fifo_data_t(logic [7:0])) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .req_w_i(b_w), .req_wok_o(b_wok), .req_wdata_i(b_wd),
    .r_i(b_r), .rok_o(b_rok), .rdata_o(b_rdata), .rid_o(b_rid));

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    a_r = 1'b1;
    cyc(); cyc();
    checks++; if (a_wok !== 4'b0000) begin errors++; $display("FAIL rst_wok: got %b want 0000", a_wok); end
    checks++; if (a_rok !== 1'b0) begin errors++; $display("FAIL rst_rok: got %b want 0", a_rok); end
    checks++; if (a_rid !== 2'd0) begin errors++; $display("FAIL rst_rid: got %0d want 0", a_rid); end
    checks++; if (b_rok !== 1'b0) begin errors++; $display("FAIL rst_b_rok: got %b want 0", b_rok); end
    a_rst = 1'b0; b_rst = 1'b0;
    cyc();
    checks++; if (a_rok !== 1'b0) begin errors++; $display("FAIL rel_rok: got %b want 0", a_rok); end
    checks++; if (a_rid !== 2'd0) begin errors++; $display("FAIL rel_rid: got %0d want 0", a_rid); end
    checks++; if (a_wok !== 4'b1111) begin errors++; $display("FAIL rel_wok: got %b want 1111", a_wok); end
    checks++; if (b_wok !== 4'b1111) begin errors++; $display("FAIL rel_b_wok: got %b want 1111", b_wok); end
    a_r = 1'b0; a_w = 4'b0011; a_wd[0] = 8'h10; a_wd[1] = 8'h11;
    cyc();
    a_w = 4'b0000;
    checks++; if (a_rok !== 1'b1 || a_rid !== 2'd0 || a_rdata !== 8'h10) begin errors++;
      $display("FAIL pre_mid_rst: got rok=%b rid=%0d data=%h want 1 0 10", a_rok, a_rid, a_rdata); end
    a_rst = 1'b1; a_w = 4'b0100; a_wd[2] = 8'h12;
    cyc();
    a_rst = 1'b0; a_w = 4'b0000;
    #1;
    checks++; if (a_rok !== 1'b0 || a_wok !== 4'b1111 || a_rid !== 2'd0) begin errors++;
      $display("FAIL mid_rst_flush: got rok=%b wok=%b rid=%0d want 0 1111 0", a_rok, a_wok, a_rid); end
    cyc();
    checks++; if (a_rok !== 1'b0) begin errors++; $display("FAIL rst_write_ignored: got rok=%b want 0", a_rok); end
  endtask

  task automatic test_rr_burst1();
    a_r = 1'b0; a_w = 4'b0101; a_wd[0] = 8'hA0; a_wd[2] = 8'hB0;
    cyc();
    a_w = 4'b0001; a_wd[0] = 8'hA1;
    cyc();
    a_w = 4'b0000; a_r = 1'b1;
    checks++; if (a_rok !== 1'b1 || a_rid !== 2'd0 || a_rdata !== 8'hA0) begin errors++;
      $display("FAIL rr_1st: got rok=%b rid=%0d data=%h want 1 0 a0", a_rok, a_rid, a_rdata); end
    cyc();
    checks++; if (a_rok !== 1'b1 || a_rid !== 2'd2 || a_rdata !== 8'hB0) begin errors++;
      $display("FAIL rr_2nd: got rok=%b rid=%0d data=%h want 1 2 b0", a_rok, a_rid, a_rdata); end
    cyc();
    checks++; if (a_rok !== 1'b1 || a_rid !== 2'd0 || a_rdata !== 8'hA1) begin errors++;
      $display("FAIL rr_3rd: got rok=%b rid=%0d data=%h want 1 0 a1", a_rok, a_rid, a_rdata); end
    cyc();
    checks++; if (a_rok !== 1'b0 || a_rid !== 2'd1) begin errors++;
      $display("FAIL rr_drained: got rok=%b rid=%0d want 0 1", a_rok, a_rid); end
    a_r = 1'b0;
  endtask

  task automatic test_backpressure();
    a_r = 1'b0; a_w = 4'b1010; a_wd[1] = 8'hC1; a_wd[3] = 8'hC3;
    cyc();
    for (int n = 0; n < 5; n++) begin
      checks++; if (a_rok !== 1'b1 || a_rid !== 2'd1 || a_rdata !== 8'hC1) begin errors++;
        $display("FAIL bp_hold%0d: got rok=%b rid=%0d data=%h want 1 1 c1", n, a_rok, a_rid, a_rdata); end
      a_w = 4'b0001; a_wd[0] = 8'hD0 + 8'(n);
      cyc();
    end
    a_w = 4'b0000; a_r = 1'b1;
    cyc();
    checks++; if (a_rok !== 1'b1 || a_rid !== 2'd3 || a_rdata !== 8'hC3) begin errors++;
      $display("FAIL bp_next: got rok=%b rid=%0d data=%h want 1 3 c3", a_rok, a_rid, a_rdata); end
    cyc();
    for (int n = 0; n < 4; n++) begin
      checks++; if (a_rok !== 1'b1 || a_rid !== 2'd0 || a_rdata !== 8'hD0 + 8'(n)) begin errors++;
        $display("FAIL bp_drain%0d: got rok=%b rid=%0d data=%h want 1 0 %h", n, a_rok, a_rid, a_rdata, 8'hD0 + 8'(n)); end
      cyc();
    end
    checks++; if (a_rok !== 1'b0) begin errors++; $display("FAIL bp_empty: got rok=%b want 0", a_rok); end
    a_r = 1'b0;
  endtask

  task automatic test_full_fifo();
    a_r = 1'b0;
    for (int n = 0; n < 4; n++) begin
      a_w = 4'b0001; a_wd[0] = 8'hE0 + 8'(n);
      cyc();
    end
    checks++; if (a_wok !== 4'b1110) begin errors++; $display("FAIL full_wok: got %b want 1110", a_wok); end
    a_wd[0] = 8'hE4;
    cyc();
    checks++; if (a_wok !== 4'b1110 || a_rdata !== 8'hE0) begin errors++;
      $display("FAIL full_reject: got wok=%b data=%h want 1110 e0", a_wok, a_rdata); end
    a_r = 1'b1; a_wd[0] = 8'hE5;
    cyc();
    a_w = 4'b0000;
    checks++; if (a_wok !== 4'b1110 || a_rid !== 2'd0 || a_rdata !== 8'hE1) begin errors++;
      $display("FAIL full_pushpop: got wok=%b rid=%0d data=%h want 1110 0 e1", a_wok, a_rid, a_rdata); end
    cyc();
    checks++; if (a_wok !== 4'b1111 || a_rdata !== 8'hE2) begin errors++;
      $display("FAIL full_order_e2: got wok=%b data=%h want 1111 e2", a_wok, a_rdata); end
    cyc();
    checks++; if (a_rdata !== 8'hE3) begin errors++; $display("FAIL full_order_e3: got %h want e3", a_rdata); end
    cyc();
    checks++; if (a_rok !== 1'b1 || a_rdata !== 8'hE5) begin errors++;
      $display("FAIL full_order_e5: got rok=%b data=%h want 1 e5", a_rok, a_rdata); end
    cyc();
    checks++; if (a_rok !== 1'b0) begin errors++; $display("FAIL full_empty: got rok=%b want 0", a_rok); end
    a_r = 1'b0;
  endtask

  task automatic test_burst2();
    logic [1:0] exp_rid [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] exp_dat [12] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31,
                                 8'h02, 8'h12, 8'h22, 8'h32};
    b_r = 1'b0;
    for (int n = 0; n < 3; n++) begin
      b_w = 4'b1111;
      for (int q = 0; q < 4; q++) b_wd[q] = 8'(q * 16 + n);
      cyc();
    end
    b_w = 4'b0000; b_r = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checks++; if (b_rok !== 1'b1 || b_rid !== exp_rid[k] || b_rdata !== exp_dat[k]) begin errors++;
        $display("FAIL burst2_pop%0d: got rok=%b rid=%0d data=%h want 1 %0d %h", k, b_rok, b_rid, b_rdata, exp_rid[k], exp_dat[k]); end
      cyc();
    end
    checks++; if (b_rok !== 1'b0) begin errors++; $display("FAIL burst2_empty: got rok=%b want 0", b_rok); end
    b_r = 1'b0;
  endtask

  task automatic test_last_pop_push();
    b_r = 1'b0; b_w = 4'b0100; b_wd[2] = 8'hF0;
    cyc();
    checks++; if (b_rok !== 1'b1 || b_rid !== 2'd2 || b_rdata !== 8'hF0) begin errors++;
      $display("FAIL lpp_head: got rok=%b rid=%0d data=%h want 1 2 f0", b_rok, b_rid, b_rdata); end
    b_r = 1'b1; b_w = 4'b0101; b_wd[2] = 8'hF1; b_wd[0] = 8'h60;
    cyc();
    b_w = 4'b0000;
    checks++; if (b_rok !== 1'b1 || b_rid !== 2'd2 || b_rdata !== 8'hF1) begin errors++;
      $display("FAIL lpp_kept: got rok=%b rid=%0d data=%h want 1 2 f1", b_rok, b_rid, b_rdata); end
    cyc();
    checks++; if (b_rok !== 1'b1 || b_rid !== 2'd0 || b_rdata !== 8'h60) begin errors++;
      $display("FAIL lpp_rotate: got rok=%b rid=%0d data=%h want 1 0 60", b_rok, b_rid, b_rdata); end
    cyc();
    checks++; if (b_rok !== 1'b0 || b_rid !== 2'd1) begin errors++;
      $display("FAIL lpp_empty: got rok=%b rid=%0d want 0 1", b_rok, b_rid); end
    b_r = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_w = 4'b0000; a_wd = '0; a_r = 1'b0;
    b_rst = 1'b1; b_w = 4'b0000; b_wd = '0; b_r = 1'b0;
    test_reset();
    test_rr_burst1();
    test_backpressure();
    test_full_fifo();
    test_burst2();
    test_last_pop_push();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
